// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr: N-channel, W-bit registered multiplexer with valid/ready on
// every input and on the output. One channel is granted per cycle, either by
// round-robin from a rotating pointer (mode=0) or by an external select
// (mode=1). The winning beat is held in a single-entry output register.
module mux_nx1_rr #(
  parameter int N_CH  = 8,
  parameter int WIDTH = 8,
  localparam int SW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SW-1:0]         sel,
  output logic [WIDTH-1:0]      out_data,
  output logic [SW-1:0]         out_chan,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // Channel vectors padded to the full index range so any SW-bit index is
  // in bounds; the padding bits read as "not valid", which also makes an
  // out-of-range sel in fixed mode produce no grant.
  localparam int NPAD = 1 << SW;

  logic [NPAD-1:0]  valid_pad;
  logic [NPAD-1:0]  ready_pad;
  logic [SW-1:0]    ptr;
  logic [SW-1:0]    ptr_next;
  logic [SW-1:0]    rr_idx;
  logic             rr_ok;
  logic [SW-1:0]    grant;
  logic             grant_ok;
  logic             free;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  // Output register can accept a new beat when empty or being drained.
  assign free = !out_valid || out_ready;

  // Zero-extend in_valid to the padded index range.
  always_comb begin
    valid_pad = '0;
    valid_pad[N_CH-1:0] = in_valid;
  end

  // Round-robin search: first valid channel starting at ptr, wrapping at N_CH.
  always_comb begin
    int idx;
    logic [SW-1:0] idx_sw;
    rr_ok  = 1'b0;
    rr_idx = '0;
    idx    = 0;
    idx_sw = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_CH) begin
        idx = idx - N_CH;
      end
      idx_sw = idx[SW-1:0];
      if (!rr_ok && valid_pad[idx_sw]) begin
        rr_ok  = 1'b1;
        rr_idx = idx_sw;
      end
    end
  end

  // Pick the grant source according to mode; reset suppresses any grant.
  always_comb begin
    grant    = rr_idx;
    grant_ok = rr_ok;
    if (mode) begin
      grant    = sel;
      grant_ok = valid_pad[sel];
    end
    if (rst) begin
      grant_ok = 1'b0;
    end
  end

  assign xfer = free && grant_ok;

  // One-hot ready at the granted channel when the output register is free.
  always_comb begin
    ready_pad = '0;
    if (xfer) begin
      ready_pad[grant] = 1'b1;
    end
    in_ready = ready_pad[N_CH-1:0];
  end

  // Data mux for the granted channel.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == SW'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer moves to the channel after the winner, wrapping from N_CH-1 to 0.
  assign ptr_next = (grant == SW'(N_CH - 1)) ? '0 : grant + 1'b1;

  // Output register: load on transfer, drain on consume, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_chan  <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer; frozen while in fixed-select mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (xfer && !mode) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed testbench for mux_nx1_rr with N_CH=8, WIDTH=8 and channel i
// carrying 8'h10+i. Inputs change 1 ns after a rising edge; outputs are
// sampled there as well.
module tb_mux_nx1_rr;

  localparam int N_CH  = 8;
  localparam int WIDTH = 8;
  localparam int SW    = 3;

  logic                  clk;
  logic                  rst;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic                  mode;
  logic [SW-1:0]         sel;
  logic [WIDTH-1:0]      out_data;
  logic [SW-1:0]         out_chan;
  logic                  out_valid;
  logic                  out_ready;

  int n_vec = 0;
  int n_err = 0;

  mux_nx1_rr #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < N_CH; i++) begin
      in_data[i*WIDTH +: WIDTH] = 8'h10 + 8'(i);
    end
    rst       = 1'b0;
    in_valid  = 8'(32'($urandom));
    mode      = 1'($urandom);
    sel       = 3'($urandom);
    out_ready = 1'($urandom);
    #1 rst = 1'b1;

    // Reset held with random inputs.
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h00);
    check("rst_out_chan",  32'(out_chan),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'h00);

    // Release with nothing valid.
    mode      = 1'b0;
    in_valid  = 8'h00;
    out_ready = 1'b1;
    rst       = 1'b0;
    tick();
    tick();
    check("rel_out_valid", 32'(out_valid), 32'd0);
    check("rel_out_data",  32'(out_data),  32'h00);
    check("rel_out_chan",  32'(out_chan),  32'd0);
    check("rel_in_ready",  32'(in_ready),  32'h00);

    // Fixed-select walk.
    mode     = 1'b1;
    in_valid = 8'hFF;
    for (int s = 0; s < N_CH; s++) begin
      sel = 3'(s);
      #1;
      check("fix_in_ready", 32'(in_ready), 32'h1 << s);
      tick();
      check("fix_out_chan",  32'(out_chan),  32'(s));
      check("fix_out_data",  32'(out_data),  32'h10 + 32'(s));
      check("fix_out_valid", 32'(out_valid), 32'd1);
    end

    // Round-robin with all channels valid: ptr still 0 after fixed mode.
    mode = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick();
      check("rr_out_chan",  32'(out_chan),  32'(c % 8));
      check("rr_out_valid", 32'(out_valid), 32'd1);
    end

    // Sparse round-robin: channels 2 and 7 only.
    in_valid = 8'b1000_0100;
    tick();
    check("sp_chan_0", 32'(out_chan), 32'd2);
    check("sp_data_0", 32'(out_data), 32'h12);
    tick();
    check("sp_chan_1", 32'(out_chan), 32'd7);
    check("sp_data_1", 32'(out_data), 32'h17);
    tick();
    check("sp_chan_2", 32'(out_chan), 32'd2);
    tick();
    check("sp_chan_3", 32'(out_chan), 32'd7);

    // Load channel 3 (ptr is 0, so only ch3 valid), then backpressure.
    in_valid = 8'h08;
    tick();
    check("bp_load_chan", 32'(out_chan), 32'd3);
    out_ready = 1'b0;
    in_valid  = 8'hFF;
    #1;
    check("bp_in_ready", 32'(in_ready), 32'h00);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_hold_data",  32'(out_data),  32'h13);
      check("bp_hold_chan",  32'(out_chan),  32'd3);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_ready", 32'(in_ready),  32'h00);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_ready", 32'(in_ready), 32'h10);
    tick();
    check("bp_next_chan",  32'(out_chan),  32'd4);
    check("bp_next_data",  32'(out_data),  32'h14);
    check("bp_next_valid", 32'(out_valid), 32'd1);

    // Mid-operation reset while FULL (ptr is 5 before the pulse).
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_in_ready",  32'(in_ready),  32'h00);
    #3;
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mr_first_ready", 32'(in_ready), 32'h01);
    tick();
    check("mr_first_chan",  32'(out_chan),  32'd0);
    check("mr_first_data",  32'(out_data),  32'h10);
    check("mr_first_valid", 32'(out_valid), 32'd1);

    // Fixed mode with the selected channel idle: drain and no reload.
    mode     = 1'b1;
    sel      = 3'd5;
    in_valid = 8'hDF;
    #1;
    check("inv_in_ready", 32'(in_ready), 32'h00);
    tick();
    check("inv_out_valid", 32'(out_valid), 32'd0);
    check("inv_out_chan",  32'(out_chan),  32'd0);
    check("inv_out_data",  32'(out_data),  32'h10);

    // Back to round-robin: ptr was frozen at 1 during fixed mode.
    mode     = 1'b0;
    in_valid = 8'hFF;
    #1;
    check("ptr_frozen_ready", 32'(in_ready), 32'h02);
    tick();
    check("ptr_frozen_chan", 32'(out_chan), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. This block is the sequential successor to the gate-level 8x1 mux. It selects one input channel per cycle, either by round-robin arbitration or by an external fixed select, and holds the chosen beat in a one-entry output register. It sits between multiple producer channels and a single consumer stage.

## Interface
- N_CH, 8, number of input channels (2..16)
- WIDTH, 8, data width per channel
- SW, $clog2(N_CH), select/channel-index width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N_CH  per-channel valid
- in_ready  out  N_CH  per-channel ready (at most one bit high)
- mode  in  1  0 = round-robin, 1 = fixed select
- sel  in  SW  channel index used when mode=1
- out_data  out  WIDTH  registered selected data
- out_chan  out  SW  index of the channel that supplied out_data
- out_valid  out  1  output register holds a beat
- out_ready  in  1  consumer accepts out_data

## Operation
- Output register state: EMPTY (out_valid=0) or FULL (out_valid=1). The register is *free* when out_valid=0 or out_ready=1.
- Grant logic (combinational), evaluated every cycle:
  - mode=0: grant = first i with in_valid[i]=1, searching ptr, ptr+1, …, N_CH-1, 0, …, ptr-1. No grant if all in_valid=0.
  - mode=1: grant = sel if sel < N_CH and in_valid[sel]=1; otherwise no grant. ptr does not change in mode 1.
- in_ready[i] = free AND grant exists AND grant==i. All other bits are 0. in_ready may depend on in_valid. in_valid must not depend on in_ready.
- Transfer on a clock edge with in_valid[g] AND in_ready[g]:
  - out_data <= in_data[g]
  - out_chan <= g
  - out_valid <= 1
  - in mode 0 only, ptr <= (g==N_CH-1) ? 0 : g+1
- Consumer takes the beat with out_ready=1 and out_valid=1. If no new transfer happens on the same edge, out_valid <= 0. out_data and out_chan keep their last values.
- Simultaneous consume and transfer: the register reloads with no bubble (out_valid stays 1).
- FULL with out_ready=0: all in_ready=0, and out_data, out_chan and out_valid are stable.
- A mode or sel change applies to the next grant evaluation. A beat already in the register is unaffected.
- ptr is an internal SW-bit register that wraps from N_CH-1 to 0. Non-power-of-2 N_CH must never yield an index ≥ N_CH.

## Timing
- Reset (async assert, sync-safe deassert): out_valid=0, out_data=0, out_chan=0, ptr=0, all in_ready=0 while rst=1.
- Latency: 1 cycle from an input handshake to out_valid/out_data.
- Throughput: 1 beat/cycle while out_ready=1 and some grant exists.
- Fairness (mode 0): with all N_CH channels continuously valid, each is granted exactly once per N_CH consecutive transfers.
- rst asserted mid-operation: the pending output beat is discarded and not delivered. The first grant after reset starts the search at channel 0.
- All outputs except in_ready are registered. in_ready is combinational from in_valid, mode, sel, ptr, out_valid and out_ready.

## Test plan
Parameters for all scenarios: N_CH=8, WIDTH=8, in_data channel i = 8'h10+i.

- Reset check: rst=1 with random inputs -> out_valid=0, out_data=8'h00, out_chan=0, in_ready=8'h00. Release with mode=0, in_valid=8'h00 -> outputs unchanged.
- Fixed mode, one-hot walk: mode=1, in_valid=8'hFF, out_ready=1, sel=0..7 in successive cycles -> one cycle later each time out_chan=sel and out_data=8'h10+sel; in_ready is one-hot at sel.
- Round-robin fairness and wrap: mode=0, in_valid=8'hFF, out_ready=1 for 16 cycles -> out_chan sequence 0,1,…,7,0,…,7 and out_valid held 1 throughout.
- Sparse round-robin: mode=0, in_valid=8'b1000_0100, out_ready=1 -> out_chan alternates 2,7,2,7. After 7 the pointer wraps and the next grant is 2.
- Backpressure: FULL with out_chan=3, out_ready=0 for 5 cycles, in_valid=8'hFF -> in_ready=0, out_data=8'h13 stable. Then out_ready=1 -> the next beat is from channel 4 on the following edge with no bubble.
- Mid-operation reset and invalid select: FULL, then rst pulsed -> out_valid=0 and the next mode-0 grant is channel 0. Separately, mode=1 with in_valid[sel]=0 -> in_ready=0 and out_valid falls after consumption.
